seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: 8-bit restoring divider, one quotient bit per SHIFT/SUB pair.
// Define DIV_SIGNED_EN for two's complement operands; default is unsigned.
module seq_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SUB,
        FIXUP,
        HOLD
    } state_t;

    state_t     state;
    state_t     next;
    logic [2:0] cnt;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] r_q;
    logic [7:0] q_q;
    logic [7:0] d_q;
    logic [8:0] trial;
    logic [7:0] a_mag;
    logic [7:0] b_mag;
    logic [7:0] q_fix;
    logic [7:0] r_fix;

    assign trial = {1'b0, r_q} - {1'b0, d_q};

`ifdef DIV_SIGNED_EN
    assign a_mag = a_q[7] ? -a_q : a_q;
    assign b_mag = b_q[7] ? -b_q : b_q;
    assign q_fix = (a_q[7] ^ b_q[7]) ? -q_q : q_q;
    assign r_fix = a_q[7] ? -r_q : r_q;
`else
    assign a_mag = a_q;
    assign b_mag = b_q;
    assign q_fix = q_q;
    assign r_fix = r_q;
`endif

    // State register; reset wins over everything, including mid-iteration.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        next = state;
        Busy = 1'b1;
        Done = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Run)
                    next = LOAD;
            end
            LOAD: begin
                if (b_q == 8'h00)
                    next = HOLD;
                else
                    next = SHIFT;
            end
            SHIFT: next = SUB;
            SUB: begin
                if (cnt == 3'd7)
                    next = FIXUP;
                else
                    next = SHIFT;
            end
            FIXUP: next = HOLD;
            HOLD: begin
                Busy = 1'b0;
                Done = 1'b1;
                if (!Run)
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Operand capture, shift/subtract datapath and result registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt       <= 3'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            r_q       <= 8'h00;
            q_q       <= 8'h00;
            d_q       <= 8'h00;
            Quotient  <= 8'h00;
            Remainder <= 8'h00;
            DivByZero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Run) begin
                        a_q <= Dividend;
                        b_q <= Divisor;
                        cnt <= 3'd0;
                    end
                end
                LOAD: begin
                    if (b_q == 8'h00) begin
                        Quotient  <= 8'hFF;
                        Remainder <= a_q;
                        DivByZero <= 1'b1;
                    end else begin
                        r_q <= 8'h00;
                        q_q <= a_mag;
                        d_q <= b_mag;
                    end
                end
                SHIFT: {r_q, q_q} <= {r_q[6:0], q_q, 1'b0};
                SUB: begin
                    if (!trial[8]) begin
                        r_q    <= trial[7:0];
                        q_q[0] <= 1'b1;
                    end
                    if (cnt != 3'd7)
                        cnt <= cnt + 3'd1;
                end
                FIXUP: begin
                    Quotient  <= q_fix;
                    Remainder <= r_fix;
                    DivByZero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
